// File: rtl/seq_pattern_gen_pkg.sv
// seq_gen_pkg: shared types for the serial pattern generator.
// FSM state encoding and the default demo pattern.
package seq_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_PAR  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1001;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: control inputs and serial outputs of the generator.
// master = stimulus side, slave = generator side.
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeats;
  logic [GAP_W-1:0] gap;
  logic             dout;
  logic             dvalid;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, repeats, gap,
    input  dout, dvalid, busy, done
  );

  modport slave (
    input  start, abort, pattern, repeats, gap,
    output dout, dvalid, busy, done
  );
endinterface

// File: rtl/seq_pattern_gen_piso_shift_reg.sv
// piso_shift_reg: PAT_W-bit parallel-load, MSB-first shifter.
// Ports: clk, reset (async, active-low), i_load, i_shift, i_data, o_next.
module piso_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [PAT_W-1:0] i_data,
  output logic             o_next
);
  logic [PAT_W-1:0] r_sr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= r_sr << 1;
    end
  end

  // MSB is already on dout when loaded, so the
  // bit below it is the one to present next.
  assign o_next = r_sr[PAT_W-2];
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: repeats a latched pattern MSB-first on dout with gaps.
// Ports: clk, reset (async, active-low), bus (slave: start, abort,
// pattern, repeats, gap -> dout, dvalid, busy, done).
// SEQ_GEN_PARITY_EN: append an even-parity bit after every copy.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  seq_pattern_gen_if.slave  bus
);
  localparam int BW = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  state_t           r_state;
  logic [PAT_W-1:0] r_pat;
  logic [CNT_W-1:0] r_rep_left;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic             r_dout;
  logic             r_dvalid;
  logic             r_busy;
  logic             r_done;

  logic             w_start;
  logic             w_last;
  logic             w_more;
  logic             w_copy_end;
  logic             w_reload;
  logic             w_load;
  logic             w_shift;
  logic             w_next;
  logic [PAT_W-1:0] w_load_data;

  assign w_start = (r_state == ST_IDLE) && bus.start;
  assign w_last  = (r_state == ST_SEND) && (r_bit_cnt == LAST_BIT);
  assign w_more  = (r_rep_left != '0);

`ifdef SEQ_GEN_PARITY_EN
  assign w_copy_end = (r_state == ST_PAR);
`else
  assign w_copy_end = w_last;
`endif

  // Next copy starts either straight after the last
  // bit (gap=0) or when the gap count expires.
  assign w_reload =
    (w_copy_end && w_more && (r_gap == '0)) ||
    ((r_state == ST_GAP) && (r_gap_cnt == r_gap));

  always_comb begin
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_load_data = r_pat;
    if (!bus.abort) begin
      if (w_start) begin
        w_load      = 1'b1;
        w_load_data = bus.pattern;
      end else if ((r_state == ST_SEND) && !w_last) begin
        w_shift = 1'b1;
      end else if (w_reload) begin
        w_load = 1'b1;
      end
    end
  end

  piso_shift_reg #(.PAT_W(PAT_W)) u_piso (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_next  (w_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_pat      <= '0;
      r_rep_left <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_dout     <= 1'b0;
      r_dvalid   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (bus.abort) begin
      r_state    <= ST_IDLE;
      r_rep_left <= '0;
      r_gap_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_dout     <= 1'b0;
      r_dvalid   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_pat      <= bus.pattern;
            r_gap      <= bus.gap;
            r_rep_left <= (bus.repeats == '0) ?
                          '0 : bus.repeats - 1'b1;
            r_bit_cnt  <= '0;
            r_dout     <= bus.pattern[PAT_W-1];
            r_dvalid   <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (!w_last) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_dout    <= w_next;
          end
`ifdef SEQ_GEN_PARITY_EN
          else begin
            r_dout  <= ^r_pat;
            r_state <= ST_PAR;
          end
`endif
        end
`ifdef SEQ_GEN_PARITY_EN
        ST_PAR: begin
        end
`endif
        ST_GAP: begin
          if (r_gap_cnt == r_gap) begin
            r_rep_left <= r_rep_left - 1'b1;
            r_bit_cnt  <= '0;
            r_dout     <= r_pat[PAT_W-1];
            r_dvalid   <= 1'b1;
            r_state    <= ST_SEND;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // End of a copy (last data bit or parity bit).
      if (w_copy_end) begin
        if (w_more && (r_gap == '0)) begin
          r_rep_left <= r_rep_left - 1'b1;
          r_bit_cnt  <= '0;
          r_dout     <= r_pat[PAT_W-1];
          r_dvalid   <= 1'b1;
          r_state    <= ST_SEND;
        end else if (w_more) begin
          r_gap_cnt <= GAP_W'(1);
          r_dout    <= 1'b0;
          r_dvalid  <= 1'b0;
          r_state   <= ST_GAP;
        end else begin
          r_dout   <= 1'b0;
          r_dvalid <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end
      end
    end
  end

  assign bus.dout   = r_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
endmodule
